nco_phase_gen: RTL and testbench
================================

Name: nco_phase_gen

Overview:
- Phase generator directly upstream of the pipelined CORDIC sin/cos stage.
- Produces one 16-bit theta per clock in the CORDIC angle convention: unsigned fraction of a turn, 0x4000 = 90°, theta[15:14] = quadrant.
- Supports three modes: fixed-frequency NCO, single linear frequency sweep (chirp), and repeating sweep.
- Configuration is latched through a load strobe; start and stop are single-cycle pulses.

Parameters:
- PHASE_W, 32, accumulator and tuning-word width.
- THETA_W, 16, output angle width; theta = acc[PHASE_W-1 -: THETA_W] + phase_ofs.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- cfg_load  in  1  pulse; latch ftw_start/ftw_step/ftw_stop/phase_ofs/mode into shadow registers
- ftw_start  in  PHASE_W  start (or fixed) frequency tuning word
- ftw_step  in  PHASE_W  per-cycle tuning-word increment in sweep modes
- ftw_stop  in  PHASE_W  sweep end tuning word
- phase_ofs  in  THETA_W  constant phase offset added to output
- mode  in  2  0 = fixed, 1 = single sweep, 2 = repeating sweep, 3 = treated as fixed
- start  in  1  pulse; begin generation
- stop  in  1  pulse; end generation
- theta  out  THETA_W  angle to CORDIC
- theta_valid  out  1  theta is a live sample
- busy  out  1  state != IDLE
- sweep_done  out  1  one-cycle pulse when the tuning word reaches ftw_stop
- phase_wrap  out  1  one-cycle pulse, aligned with the first theta sample after an accumulator carry-out

Behaviour:
- Reset: all outputs 0, acc = 0, ftw_cur = 0, all shadow registers 0, state IDLE.
- States: IDLE, RUN (fixed), SWEEP, HOLD. busy = (state != IDLE).
- cfg_load:
  - Honoured only in IDLE; ignored when busy.
  - Shadow registers are used from the next cycle.
  - cfg_load and start in the same cycle: start uses the old shadow values.
- start in IDLE, cycle T:
  - At T+1: acc = 0, ftw_cur = ftw_start.
  - Next state: RUN for mode 0/3, SWEEP for mode 1/2.
  - start is ignored when busy.
- Every cycle in RUN/SWEEP/HOLD: acc <= acc + ftw_cur, modulo 2^PHASE_W. A carry-out sets phase_wrap on the next registered sample.
- theta register:
  - theta <= acc[31:16] + phase_ofs (mod 2^16), registered from the current acc.
  - theta_valid <= busy.
  - First valid sample at T+2 equals phase_ofs, i.e. 2-cycle start latency.
- SWEEP, each cycle:
  - If ftw_cur + ftw_step (33-bit compare) >= ftw_stop: ftw_cur <= ftw_stop and sweep_done pulses next cycle. Then mode 1 -> HOLD; mode 2 -> ftw_cur is reloaded with ftw_start on the following cycle and the state stays SWEEP.
  - Otherwise ftw_cur <= ftw_cur + ftw_step.
- Boundary: ftw_start >= ftw_stop in a sweep mode clamps on the first SWEEP cycle. ftw_step = 0 with ftw_start < ftw_stop sweeps indefinitely at ftw_start and never pulses sweep_done.
- HOLD: generates at ftw_stop until stop.
- stop in any busy state:
  - State -> IDLE next cycle.
  - theta_valid drops one cycle later.
  - theta holds its last value; acc and ftw_cur freeze.
- stop and start in the same cycle: stop wins. From IDLE this is a no-op.
- Reset asserted mid-operation: immediate return to reset values, including shadow registers.
- Downstream has no backpressure: theta advances every cycle while valid.

Decomposition:
- Package nco_pkg:
  - PHASE_W, THETA_W
  - mode encodings MODE_FIXED/MODE_SWEEP1/MODE_SWEEPR
  - state enum
  - THETA_QUARTER = 16'h4000
- One natural sub-module, nco_sweep_ctrl: the FSM plus the ftw_cur ramp and compare, outputting ftw_cur, busy, sweep_done.
- Accumulator and output register stay in the top.

Test Plan:
- Fixed mode, ftw_start = 0x4000_0000, phase_ofs = 0, start -> from T+2 theta = 0x0000, 0x4000, 0x8000, 0xC000, 0x0000. phase_wrap = 1 only on the second 0x0000 sample. busy = 1 from T+1.
- Same setup with phase_ofs = 0x2000 -> 0x2000, 0x6000, 0xA000, 0xE000, 0x2000. Confirms offset wrap.
- Single sweep, ftw_start = 0x0100_0000, step = 0x0100_0000, stop = 0x0400_0000 -> ftw_cur = 1, 2, 3, 4 (x0x0100_0000). Exactly one sweep_done pulse, then state HOLD with a constant theta increment of 0x0400.
- Repeating sweep, same words -> sweep_done pulses periodically, once per ramp. The ftw_cur sequence 1, 2, 3, 4, 1, ... (x0x0100_0000) repeats.
- stop in SWEEP -> busy = 0 next cycle, theta_valid = 0 one cycle later, theta frozen. A new start restarts from acc = 0 (first theta = phase_ofs).
- cfg_load while busy is ignored (the output sequence is unchanged). Asserting rstn low mid-sweep forces all outputs to 0 asynchronously.

Source files
------------

// File: rtl/nco_pkg.sv
// ---------------------------------------------------------------------------
// nco_pkg : shared widths, mode encodings and FSM states for nco_phase_gen
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package nco_pkg;

  localparam int PHASE_W = 32;
  localparam int THETA_W = 16;

  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_SWEEP1 = 2'd1;
  localparam logic [1:0] MODE_SWEEPR = 2'd2;

  localparam logic [15:0] THETA_QUARTER = 16'h4000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_SWEEP = 2'd2,
    ST_HOLD  = 2'd3
  } state_t;

  function automatic logic is_sweep_mode(input logic [1:0] m);
    return (m == MODE_SWEEP1) || (m == MODE_SWEEPR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/nco_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// nco_sweep_ctrl : run/sweep/hold FSM and tuning-word ramp with end clamp
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nco_sweep_ctrl #(
  parameter int PHASE_W = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic [PHASE_W-1:0] ftw_start,
  input  logic [PHASE_W-1:0] ftw_step,
  input  logic [PHASE_W-1:0] ftw_stop,
  output logic [PHASE_W-1:0] ftw_cur,
  output logic               busy,
  output logic               sweep_done
);
  import nco_pkg::*;

  state_t             state, state_nxt;
  logic [PHASE_W-1:0] ftw_nxt;
  logic               done_nxt;
  logic               reload, reload_nxt;
  logic [PHASE_W:0]   ramp_sum;

  // One extra bit so the compare stays correct when the ramp overflows
  assign ramp_sum = {1'b0, ftw_cur} + {1'b0, ftw_step};
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      ftw_cur    <= '0;
      sweep_done <= 1'b0;
      reload     <= 1'b0;
    end else begin
      state      <= state_nxt;
      ftw_cur    <= ftw_nxt;
      sweep_done <= done_nxt;
      reload     <= reload_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    ftw_nxt    = ftw_cur;
    done_nxt   = 1'b0;
    reload_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          ftw_nxt   = ftw_start;
          state_nxt = is_sweep_mode(mode) ? ST_SWEEP : ST_RUN;
        end
      end
      ST_SWEEP: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end else if (reload) begin
          ftw_nxt = ftw_start;
        end else if (ramp_sum >= {1'b0, ftw_stop}) begin
          ftw_nxt  = ftw_stop;
          done_nxt = 1'b1;
          if (mode == MODE_SWEEPR) begin
            reload_nxt = 1'b1;
          end else begin
            state_nxt = ST_HOLD;
          end
        end else begin
          ftw_nxt = ramp_sum[PHASE_W-1:0];
        end
      end
      default: begin
        if (stop) begin
          state_nxt = ST_IDLE;
        end
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/nco_phase_gen.sv
// ---------------------------------------------------------------------------
// nco_phase_gen : NCO / chirp phase generator feeding the CORDIC angle input
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nco_phase_gen #(
  parameter int PHASE_W = 32,
  parameter int THETA_W = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               cfg_load,
  input  logic [PHASE_W-1:0] ftw_start,
  input  logic [PHASE_W-1:0] ftw_step,
  input  logic [PHASE_W-1:0] ftw_stop,
  input  logic [THETA_W-1:0] phase_ofs,
  input  logic [1:0]         mode,
  input  logic               start,
  input  logic               stop,
  output logic [THETA_W-1:0] theta,
  output logic               theta_valid,
  output logic               busy,
  output logic               sweep_done,
  output logic               phase_wrap
);

  logic [PHASE_W-1:0] start_q, step_q, stop_q;
  logic [THETA_W-1:0] ofs_q;
  logic [1:0]         mode_q;
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] ftw_cur;
  logic [PHASE_W:0]   acc_sum;
  logic               carry_q;
  logic               launch;

  assign acc_sum = {1'b0, acc} + {1'b0, ftw_cur};
  assign launch  = start && !stop && !busy;

  nco_sweep_ctrl #(
    .PHASE_W (PHASE_W)
  ) u_ctrl (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .stop       (stop),
    .mode       (mode_q),
    .ftw_start  (start_q),
    .ftw_step   (step_q),
    .ftw_stop   (stop_q),
    .ftw_cur    (ftw_cur),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      start_q     <= '0;
      step_q      <= '0;
      stop_q      <= '0;
      ofs_q       <= '0;
      mode_q      <= '0;
      acc         <= '0;
      carry_q     <= 1'b0;
      theta       <= '0;
      theta_valid <= 1'b0;
      phase_wrap  <= 1'b0;
    end else begin
      if (cfg_load && !busy) begin
        start_q <= ftw_start;
        step_q  <= ftw_step;
        stop_q  <= ftw_stop;
        ofs_q   <= phase_ofs;
        mode_q  <= mode;
      end
      // Carry is held one cycle so the wrap flag lines up with the sample it caused
      if (launch) begin
        acc     <= '0;
        carry_q <= 1'b0;
      end else if (busy) begin
        acc     <= acc_sum[PHASE_W-1:0];
        carry_q <= acc_sum[PHASE_W];
      end else begin
        carry_q <= 1'b0;
      end
      if (busy) begin
        theta <= acc[PHASE_W-1 -: THETA_W] + ofs_q;
      end
      theta_valid <= busy;
      phase_wrap  <= carry_q && busy;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nco_phase_gen.sv
// ---------------------------------------------------------------------------
// tb_nco_phase_gen : directed self-checking bench for nco_phase_gen
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_nco_phase_gen;
  import nco_pkg::*;

  logic        clk;
  logic        rstn;
  logic        cfg_load;
  logic [31:0] ftw_start, ftw_step, ftw_stop;
  logic [15:0] phase_ofs;
  logic [1:0]  mode;
  logic        start, stop;
  logic [15:0] theta;
  logic        theta_valid, busy, sweep_done, phase_wrap;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] t_fix [0:4] = '{16'h0000, THETA_QUARTER, 16'h8000, 16'hC000, 16'h0000};
  logic [15:0] t_ofs [0:4] = '{16'h2000, 16'h6000, 16'hA000, 16'hE000, 16'h2000};
  logic [15:0] t_s1  [0:6] = '{16'h0000, 16'h0100, 16'h0300, 16'h0600, 16'h0A00, 16'h0E00, 16'h1200};
  logic [15:0] t_sr  [0:8] = '{16'h0000, 16'h0100, 16'h0300, 16'h0600, 16'h0A00,
                               16'h0B00, 16'h0D00, 16'h1000, 16'h1400};
  logic [15:0] t_cl  [0:3] = '{16'h0000, 16'h0500, 16'h0900, 16'h0D00};

  nco_phase_gen #(
    .PHASE_W (32),
    .THETA_W (16)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cfg_load    (cfg_load),
    .ftw_start   (ftw_start),
    .ftw_step    (ftw_step),
    .ftw_stop    (ftw_stop),
    .phase_ofs   (phase_ofs),
    .mode        (mode),
    .start       (start),
    .stop        (stop),
    .theta       (theta),
    .theta_valid (theta_valid),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .phase_wrap  (phase_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input logic [31:0] f0, input logic [31:0] fs, input logic [31:0] f1,
                     input logic [15:0] ofs, input logic [1:0] m);
    ftw_start = f0;
    ftw_step  = fs;
    ftw_stop  = f1;
    phase_ofs = ofs;
    mode      = m;
    cfg_load  = 1'b1;
    step();
    cfg_load  = 1'b0;
  endtask

  // Returns one cycle after the start edge (T+1)
  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_at_T1", 32'(busy), 32'd1);
    check("valid_at_T1", 32'(theta_valid), 32'd0);
  endtask

  task automatic halt(input logic [15:0] frozen);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", 32'(busy), 32'd0);
    check("stop_valid_lag", 32'(theta_valid), 32'd1);
    check("stop_theta", 32'(theta), 32'(frozen));
    step();
    check("stop_valid_drop", 32'(theta_valid), 32'd0);
    check("stop_theta_hold", 32'(theta), 32'(frozen));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; cfg_load = 1'b0; start = 1'b0; stop = 1'b0;
    ftw_start = '0; ftw_step = '0; ftw_stop = '0; phase_ofs = '0; mode = MODE_FIXED;
    step(); step();
    check("rst_theta", 32'(theta), 32'd0);
    check("rst_valid", 32'(theta_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(sweep_done), 32'd0);
    check("rst_wrap", 32'(phase_wrap), 32'd0);
    rstn = 1'b1;
    step();

    // Fixed frequency, quarter turn per cycle
    cfg(32'h4000_0000, 32'h0, 32'h0, 16'h0000, MODE_FIXED);
    go();
    for (int i = 0; i < 5; i++) begin
      step();
      check("fix_theta", 32'(theta), 32'(t_fix[i]));
      check("fix_wrap", 32'(phase_wrap), 32'(i == 4));
      check("fix_valid", 32'(theta_valid), 32'd1);
    end
    halt(16'h4000);

    // Same tone with phase offset
    cfg(32'h4000_0000, 32'h0, 32'h0, 16'h2000, MODE_FIXED);
    go();
    for (int i = 0; i < 5; i++) begin
      step();
      check("ofs_theta", 32'(theta), 32'(t_ofs[i]));
      check("ofs_wrap", 32'(phase_wrap), 32'(i == 4));
    end
    halt(16'h6000);

    // Single sweep 1..4 then hold
    cfg(32'h0100_0000, 32'h0100_0000, 32'h0400_0000, 16'h0000, MODE_SWEEP1);
    go();
    check("s1_done_T1", 32'(sweep_done), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step();
      check("s1_theta", 32'(theta), 32'(t_s1[i]));
      check("s1_done", 32'(sweep_done), 32'(i == 2));
      check("s1_busy", 32'(busy), 32'd1);
    end
    halt(16'h1600);

    // Repeating sweep; a cfg_load while busy must not disturb it
    cfg(32'h0100_0000, 32'h0100_0000, 32'h0400_0000, 16'h0000, MODE_SWEEPR);
    go();
    for (int i = 0; i < 9; i++) begin
      step();
      check("sr_theta", 32'(theta), 32'(t_sr[i]));
      check("sr_done", 32'(sweep_done), 32'(i == 2 || i == 6));
      if (i == 3) begin
        ftw_start = 32'hDEAD_BEEF; ftw_step = 32'h1; ftw_stop = 32'hFFFF_FFFF;
        phase_ofs = 16'h1234; mode = MODE_FIXED; cfg_load = 1'b1;
      end else begin
        cfg_load = 1'b0;
      end
    end
    halt(16'h1500);

    // Restart after stop begins again from acc = 0
    go();
    step();
    check("restart_theta0", 32'(theta), 32'h0000);
    check("restart_valid", 32'(theta_valid), 32'd1);
    step();
    check("restart_theta1", 32'(theta), 32'h0100);
    step();
    check("restart_theta2", 32'(theta), 32'h0300);

    // Asynchronous reset mid-sweep
    #2 rstn = 1'b0;
    #1;
    check("arst_theta", 32'(theta), 32'd0);
    check("arst_valid", 32'(theta_valid), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(sweep_done), 32'd0);
    check("arst_wrap", 32'(phase_wrap), 32'd0);
    step();
    rstn = 1'b1;
    step();

    // Shadow registers were cleared: fixed mode, zero tuning word
    go();
    step(); step();
    check("shadow_clr_theta", 32'(theta), 32'd0);
    check("shadow_clr_busy", 32'(busy), 32'd1);
    halt(16'h0000);

    // Simultaneous start+stop from IDLE is a no-op
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 32'd0);
    step();
    check("startstop_valid", 32'(theta_valid), 32'd0);

    // ftw_start above ftw_stop clamps on the first sweep cycle
    cfg(32'h0500_0000, 32'h0100_0000, 32'h0400_0000, 16'h0000, MODE_SWEEP1);
    go();
    for (int i = 0; i < 4; i++) begin
      step();
      check("clamp_theta", 32'(theta), 32'(t_cl[i]));
      check("clamp_done", 32'(sweep_done), 32'(i == 0));
    end
    halt(16'h1100);

    // Zero step never reaches ftw_stop
    cfg(32'h0100_0000, 32'h0, 32'h0400_0000, 16'h0000, MODE_SWEEP1);
    go();
    for (int i = 0; i < 6; i++) begin
      step();
      check("step0_theta", 32'(theta), 32'(i) << 8);
      check("step0_done", 32'(sweep_done), 32'd0);
    end
    halt(16'h0600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
